// File: rtl/clk_div_cfg_arbiter.sv
// Round-robin arbiter that sequences clock-divider reconfiguration glitch-safely:
// gate the divider, settle, load N_div/invert, settle, re-enable, then acknowledge.
module clk_div_cfg_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int DIV_W         = 4,
    parameter int MAX_DIV       = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESET_DIV     = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*DIV_W-1:0] req_N_div,
    input  logic [NUM_REQ-1:0]       req_enable,
    input  logic [NUM_REQ-1:0]       req_invert,
    output logic [NUM_REQ-1:0]       ack,
    output logic                     err,
    output logic                     busy,
    output logic [DIV_W-1:0]         N_div,
    output logic                     clockEnable,
    output logic                     invert
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [DIV_W:0]   MAX_DIV_EXT = (DIV_W+1)'(MAX_DIV);
    localparam logic [CNT_W-1:0] CNT_TERM    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {IDLE, GATE, LOAD, RESP} state_t;

    state_t             state_reg;
    logic [IDX_W-1:0]   rr_reg;
    logic [IDX_W-1:0]   grant_reg;
    logic [DIV_W-1:0]   lat_div_reg;
    logic               lat_en_reg;
    logic               lat_inv_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [NUM_REQ-1:0] ack_reg;
    logic               err_reg;
    logic               busy_reg;
    logic [DIV_W-1:0]   n_div_reg;
    logic               ce_reg;
    logic               inv_reg;

    logic [DIV_W-1:0]   cfg_div [NUM_REQ];
    logic [NUM_REQ-1:0] eligible;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [DIV_W-1:0]   win_div;
    logic               win_en;
    logic               win_inv;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cfg_slice
            assign cfg_div[gi] = req_N_div[gi*DIV_W +: DIV_W];
        end
    endgenerate

    assign eligible = req & ~ack_reg;

    // Search starts one past the last grant so every requester gets a turn.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_reg) + k) % NUM_REQ);
            if (!win_found && eligible[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign win_div = cfg_div[win_idx];
    assign win_en  = req_enable[win_idx];
    assign win_inv = req_invert[win_idx];

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            rr_reg      <= IDX_W'(NUM_REQ - 1);
            grant_reg   <= '0;
            lat_div_reg <= '0;
            lat_en_reg  <= 1'b0;
            lat_inv_reg <= 1'b0;
            cnt_reg     <= '0;
            ack_reg     <= '0;
            err_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            n_div_reg   <= DIV_W'(RESET_DIV);
            ce_reg      <= 1'b0;
            inv_reg     <= 1'b0;
        end else begin
            if (cnt_reg != CNT_SAT) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (win_found) begin
                        grant_reg   <= win_idx;
                        rr_reg      <= win_idx;
                        lat_div_reg <= win_div;
                        lat_en_reg  <= win_en;
                        lat_inv_reg <= win_inv;
                        busy_reg    <= 1'b1;
                        if ({1'b0, win_div} > MAX_DIV_EXT) begin
                            ack_reg[win_idx] <= 1'b1;
                            err_reg          <= 1'b1;
                            state_reg        <= RESP;
                        end else if ({win_div, win_en, win_inv} == {n_div_reg, ce_reg, inv_reg}) begin
                            // Nothing to change, so the divider is never gated.
                            ack_reg[win_idx] <= 1'b1;
                            state_reg        <= RESP;
                        end else begin
                            ce_reg    <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= GATE;
                        end
                    end
                end
                GATE: begin
                    if (cnt_reg >= CNT_TERM) begin
                        n_div_reg <= lat_div_reg;
                        inv_reg   <= lat_inv_reg;
                        cnt_reg   <= '0;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    if (cnt_reg >= CNT_TERM) begin
                        ce_reg             <= lat_en_reg;
                        ack_reg[grant_reg] <= 1'b1;
                        err_reg            <= 1'b0;
                        state_reg          <= RESP;
                    end
                end
                RESP: begin
                    if (!req[grant_reg]) begin
                        ack_reg   <= '0;
                        err_reg   <= 1'b0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack         = ack_reg;
    assign err         = err_reg;
    assign busy        = busy_reg;
    assign N_div       = n_div_reg;
    assign clockEnable = ce_reg;
    assign invert      = inv_reg;

endmodule

// File: tb/tb_clk_div_cfg_arbiter.sv
// Scoreboard bench: stimulus queues the expected acknowledge record, a negedge
// monitor pops and compares it (requester, err, divider outputs, latency from busy).
module tb_clk_div_cfg_arbiter;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [7:0] req_N_div;
    logic [1:0] req_enable;
    logic [1:0] req_invert;
    logic [1:0] ack;
    logic       err;
    logic       busy;
    logic [3:0] N_div;
    logic       clockEnable;
    logic       invert;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        int         idx;
        logic       err;
        logic [3:0] n;
        logic       ce;
        logic       inv;
        int         lat;
    } exp_t;

    exp_t exp_q[$];

    clk_div_cfg_arbiter #(
        .NUM_REQ(2), .DIV_W(4), .MAX_DIV(4), .SETTLE_CYCLES(4), .RESET_DIV(1)
    ) dut (
        .clk_in(clk_in), .rst_n(rst_n), .req(req), .req_N_div(req_N_div),
        .req_enable(req_enable), .req_invert(req_invert), .ack(ack), .err(err),
        .busy(busy), .N_div(N_div), .clockEnable(clockEnable), .invert(invert)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic push(input int idx, input logic e, input logic [3:0] n,
                        input logic ce, input logic inv, input int lat);
        exp_t x;
        x.idx = idx; x.err = e; x.n = n; x.ce = ce; x.inv = inv; x.lat = lat;
        exp_q.push_back(x);
    endtask

    task automatic set_cfg(input int idx, input logic [3:0] n, input logic en, input logic inv);
        req_N_div[idx*4 +: 4] = n;
        req_enable[idx]       = en;
        req_invert[idx]       = inv;
    endtask

    task automatic wait_ack(input int idx);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (ack[idx]) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL wait_ack%0d: got timeout expected ack within 40 cycles", idx);
    endtask

    task automatic drop_req(input int idx);
        req[idx] = 1'b0;
        @(negedge clk_in);
        check($sformatf("drop%0d_ack", idx), 32'(ack[idx]), 32'd0);
        check($sformatf("drop%0d_err", idx), 32'(err), 32'd0);
    endtask

    // Monitor: compares each acknowledge against the oldest queued expectation.
    initial begin
        int   cyc = 0;
        int   start = 0;
        logic prev_busy = 1'b0;
        logic [1:0] prev_ack = 2'b00;
        exp_t x;
        forever begin
            @(negedge clk_in);
            if (!rst_n) begin
                prev_busy = 1'b0;
                prev_ack  = 2'b00;
            end else begin
                cyc++;
                if (busy && !prev_busy) start = cyc;
                if (ack != 2'b00) check("mon_onehot", 32'($countones(ack)), 32'd1);
                if (ack != 2'b00 && prev_ack == 2'b00) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL mon_unexpected: got ack=%b expected no ack", ack);
                    end else begin
                        x = exp_q.pop_front();
                        $display("ack req%0d err=%b N_div=%0d ce=%b inv=%b lat=%0d",
                                 x.idx, err, N_div, clockEnable, invert, cyc - start);
                        check("mon_ack", 32'(ack), 32'(2'b01 << x.idx));
                        check("mon_err", 32'(err), 32'(x.err));
                        check("mon_ndiv", 32'(N_div), 32'(x.n));
                        check("mon_ce", 32'(clockEnable), 32'(x.ce));
                        check("mon_inv", 32'(invert), 32'(x.inv));
                        check("mon_lat", 32'(cyc - start), 32'(x.lat));
                    end
                end
                prev_busy = busy;
                prev_ack  = ack;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req = 2'b00; req_N_div = 8'h00; req_enable = 2'b00; req_invert = 2'b00;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        check("rst_ndiv", 32'(N_div), 32'd1);
        check("rst_ce", 32'(clockEnable), 32'd0);
        check("rst_inv", 32'(invert), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk_in);
        check("idle_ndiv", 32'(N_div), 32'd1);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_ack", 32'(ack), 32'd0);

        // Full sequence with per-phase timing checks.
        set_cfg(0, 4'd2, 1'b1, 1'b0);
        push(0, 1'b0, 4'd2, 1'b1, 1'b0, 8);
        req[0] = 1'b1;
        @(negedge clk_in);
        check("t2_ce_e0", 32'(clockEnable), 32'd0);
        check("t2_busy_e0", 32'(busy), 32'd1);
        repeat (3) @(negedge clk_in);
        check("t2_ndiv_e3", 32'(N_div), 32'd1);
        @(negedge clk_in);
        check("t2_ndiv_e4", 32'(N_div), 32'd2);
        check("t2_ce_e4", 32'(clockEnable), 32'd0);
        repeat (3) @(negedge clk_in);
        check("t2_ce_e7", 32'(clockEnable), 32'd0);
        check("t2_ack_e7", 32'(ack), 32'd0);
        @(negedge clk_in);
        check("t2_ce_e8", 32'(clockEnable), 32'd1);
        check("t2_ack_e8", 32'(ack), 32'd1);
        drop_req(0);
        check("t2_busy_end", 32'(busy), 32'd0);

        // Tie after grant 0: requester 1 first, then 0.
        set_cfg(0, 4'd3, 1'b1, 1'b1);
        set_cfg(1, 4'd4, 1'b1, 1'b0);
        push(1, 1'b0, 4'd4, 1'b1, 1'b0, 8);
        push(0, 1'b0, 4'd3, 1'b1, 1'b1, 8);
        req = 2'b11;
        wait_ack(1);
        drop_req(1);
        wait_ack(0);
        drop_req(0);

        // Out-of-range request is rejected at once without touching the divider.
        set_cfg(1, 4'd7, 1'b0, 1'b0);
        push(1, 1'b1, 4'd3, 1'b1, 1'b1, 0);
        req[1] = 1'b1;
        wait_ack(1);
        drop_req(1);

        // Tie after grant 1: requester 0 wins with its unchanged config.
        set_cfg(0, 4'd3, 1'b1, 1'b1);
        set_cfg(1, 4'd2, 1'b1, 1'b0);
        push(0, 1'b0, 4'd3, 1'b1, 1'b1, 0);
        push(1, 1'b0, 4'd2, 1'b1, 1'b0, 8);
        req = 2'b11;
        wait_ack(0);
        check("t5_ce_hold", 32'(clockEnable), 32'd1);
        drop_req(0);
        wait_ack(1);
        drop_req(1);

        // Repeat of the current config: clockEnable must never drop.
        set_cfg(0, 4'd2, 1'b1, 1'b0);
        push(0, 1'b0, 4'd2, 1'b1, 1'b0, 0);
        req[0] = 1'b1;
        wait_ack(0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            check("t6_ce_stay", 32'(clockEnable), 32'd1);
            check("t6_ack_hold", 32'(ack), 32'd1);
        end
        drop_req(0);

        // Bypass divide; config changed after grant must be ignored.
        set_cfg(1, 4'd0, 1'b1, 1'b0);
        push(1, 1'b0, 4'd0, 1'b1, 1'b0, 8);
        req[1] = 1'b1;
        @(negedge clk_in);
        set_cfg(1, 4'd5, 1'b0, 1'b1);
        wait_ack(1);
        drop_req(1);

        // MAX_DIV boundary, disabled output, request withdrawn mid-sequence.
        set_cfg(0, 4'd4, 1'b0, 1'b1);
        push(0, 1'b0, 4'd4, 1'b0, 1'b1, 8);
        req[0] = 1'b1;
        repeat (3) @(negedge clk_in);
        req[0] = 1'b0;
        wait_ack(0);
        @(negedge clk_in);
        check("t8_ack_one_cycle", 32'(ack), 32'd0);
        check("t8_busy_end", 32'(busy), 32'd0);

        // Reset during the gate phase aborts; the held request is redone from scratch.
        set_cfg(0, 4'd1, 1'b1, 1'b0);
        req[0] = 1'b1;
        repeat (3) @(negedge clk_in);
        check("t9_busy_gate", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t9_rst_ndiv", 32'(N_div), 32'd1);
        check("t9_rst_inv", 32'(invert), 32'd0);
        check("t9_rst_ce", 32'(clockEnable), 32'd0);
        check("t9_rst_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_in);
            check("t9_rst_ack", 32'(ack), 32'd0);
        end
        push(0, 1'b0, 4'd1, 1'b1, 1'b0, 8);
        rst_n = 1'b1;
        wait_ack(0);
        drop_req(0);

        repeat (3) @(negedge clk_in);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
